// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair.
package prbs_pkg;

  localparam int LFSR_W = 8;

  // Feedback taps at bits 7,5,4,3 give the maximal-length (255-state) sequence.
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

  typedef enum logic [1:0] {
    SEARCH_SEED   = 2'd0,
    SEARCH_VERIFY = 2'd1,
    LOCKED        = 2'd2
  } state_t;

  // Next LFSR state: shift left and insert the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the incoming stream, verifies a
// run of correct predictions before locking, then flywheels through errors and
// counts them until too many consecutive misses drop lock.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              data_valid,
  input  logic [LFSR_W-1:0] data_in,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        state_out
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t              r_state;
  logic [LFSR_W-1:0]   r_exp;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [MISS_W-1:0]   r_miss_cnt;
  logic                r_locked;
  logic                r_err_pulse;
  logic [ERR_W-1:0]    r_err_count;

  logic [LFSR_W-1:0]   w_pred;
  logic                w_match;
  logic                w_nonzero;
  logic                w_locked_miss;
  logic [MATCH_W-1:0]  w_match_inc;
  logic [MISS_W-1:0]   w_miss_inc;

  assign w_pred        = lfsr_next(r_exp);
  assign w_match       = (data_in == w_pred);
  assign w_nonzero     = (data_in != '0);
  assign w_locked_miss = data_valid && (r_state == LOCKED) && !w_match;
  assign w_match_inc   = r_match_cnt + MATCH_W'(1);
  assign w_miss_inc    = r_miss_cnt + MISS_W'(1);

  // Synchronisation FSM with registered lock flag and error strobe.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH_SEED;
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_locked_miss;
      case (r_state)
        SEARCH_SEED: begin
          // An all-zero sample is the LFSR lock-up state and cannot seed.
          if (data_valid && w_nonzero) begin
            r_exp       <= data_in;
            r_match_cnt <= '0;
            r_state     <= SEARCH_VERIFY;
          end
        end
        SEARCH_VERIFY: begin
          if (data_valid) begin
            if (w_match) begin
              r_exp       <= data_in;
              r_match_cnt <= w_match_inc;
              if (w_match_inc == MATCH_W'(LOCK_COUNT)) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else if (w_nonzero) begin
              r_exp       <= data_in;
              r_match_cnt <= '0;
            end else begin
              r_state <= SEARCH_SEED;
            end
          end
        end
        LOCKED: begin
          if (data_valid) begin
            if (w_match) begin
              r_exp      <= data_in;
              r_miss_cnt <= '0;
            end else begin
              // Flywheel: keep following the predicted sequence, not the bad sample.
              r_exp      <= w_pred;
              r_miss_cnt <= w_miss_inc;
              if (w_miss_inc == MISS_W'(LOSS_COUNT)) begin
                r_state  <= SEARCH_SEED;
                r_locked <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state  <= SEARCH_SEED;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; clear wins over a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (clear) begin
      r_err_count <= '0;
    end else if (w_locked_miss && (r_err_count != ERR_MAX)) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign state_out = r_state;

endmodule
